// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the shared 32-bit ALU
// for sign fix-up, shift-add multiply and restoring-divide steps into HI/LO.
module alu_muldiv_seq #(
  parameter logic [31:0] DIV0_LO   = 32'hFFFFFFFF,
  parameter bit          DIV0_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_req,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_r
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NEG_A = 3'd1;
  localparam logic [2:0] S_NEG_B = 3'd2;
  localparam logic [2:0] S_ITER  = 3'd3;
  localparam logic [2:0] S_FIX1  = 3'd4;
  localparam logic [2:0] S_FIX2  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0010;

  logic [2:0]  state;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;        // raw operands as latched at start
  logic [31:0] mag_a, mag_b;    // |A|, |B| after NEG_A / NEG_B
  logic [31:0] reg_h, reg_l;    // H/L for multiply, R/Q for divide
  logic [4:0]  cnt;
  logic        sa, sb, lz, div0;

  logic        is_div, neg_res, idle_or_done, start_div0;
  logic [31:0] div_t, mul_sum, neg_b_val;
  logic        mul_c, borrow;

  assign is_div       = op_q[1];
  assign neg_res      = sa ^ sb;
  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign start_div0   = op[1] && (rt == 32'h0);

  assign busy    = !idle_or_done;
  assign alu_req = busy;
  assign done    = (state == S_DONE);

  // Carry/borrow are recovered from operand and result sign bits because the ALU has no flags.
  assign div_t     = {reg_h[30:0], reg_l[31]};
  assign mul_sum   = reg_l[0] ? alu_r : reg_h;
  assign mul_c     = reg_l[0] & ((alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_r[31]));
  assign borrow    = (~alu_a[31] & alu_b[31]) | ((~alu_a[31] | alu_b[31]) & alu_r[31]);
  assign neg_b_val = sb ? alu_r : b_q;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    alu_a    = 32'h0;
    alu_b    = 32'h0;
    alu_aluc = ALU_ADD;
    case (state)
      S_NEG_A: begin alu_b = a_q; alu_aluc = ALU_SUB; end
      S_NEG_B: begin alu_b = b_q; alu_aluc = ALU_SUB; end
      S_ITER: begin
        if (is_div) begin
          alu_a    = div_t;
          alu_b    = mag_b;
          alu_aluc = ALU_SUB;
        end else begin
          alu_a = reg_h;
          alu_b = reg_l[0] ? mag_a : 32'h0;
        end
      end
      S_FIX1: begin alu_b = reg_l; alu_aluc = ALU_SUB; end
      S_FIX2: begin
        if (is_div || lz) begin
          alu_b    = reg_h;
          alu_aluc = ALU_SUB;
        end else begin
          alu_a    = reg_h;
          alu_b    = 32'hFFFFFFFF;
          alu_aluc = ALU_XOR;
        end
      end
      default: ;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= 2'b00;
      a_q   <= 32'h0;
      b_q   <= 32'h0;
      mag_a <= 32'h0;
      mag_b <= 32'h0;
      reg_h <= 32'h0;
      reg_l <= 32'h0;
      cnt   <= 5'd0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      lz    <= 1'b0;
      div0  <= 1'b0;
      hi    <= 32'h0;
      lo    <= 32'h0;
    end else begin
      case (state)
        S_NEG_A: begin
          mag_a <= sa ? alu_r : a_q;
          state <= S_NEG_B;
        end
        S_NEG_B: begin
          mag_b <= neg_b_val;
          reg_h <= 32'h0;
          reg_l <= is_div ? mag_a : neg_b_val;
          cnt   <= 5'd0;
          state <= S_ITER;
        end
        S_ITER: begin
          if (is_div) begin
            if (reg_h[31] || !borrow) begin
              reg_h <= alu_r;
              reg_l <= {reg_l[30:0], 1'b1};
            end else begin
              reg_h <= div_t;
              reg_l <= {reg_l[30:0], 1'b0};
            end
          end else begin
            reg_h <= {mul_c, mul_sum[31:1]};
            reg_l <= {mul_sum[0], reg_l[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX1;
        end
        S_FIX1: begin
          lz <= (reg_l == 32'h0);
          if (neg_res) reg_l <= alu_r;
          state <= S_FIX2;
        end
        S_FIX2: begin
          // hi/lo change only here, so partial results never become visible.
          if (div0) begin
            hi <= a_q;
            lo <= DIV0_LO;
          end else begin
            hi <= (is_div ? sa : neg_res) ? alu_r : reg_h;
            lo <= reg_l;
          end
          state <= S_DONE;
        end
        default: begin
          if (idle_or_done && start) begin
            op_q <= op;
            a_q  <= rs;
            b_q  <= rt;
            sa   <= ~op[0] & rs[31];
            sb   <= ~op[0] & rt[31];
            div0 <= start_div0;
            if (DIV0_FAST && start_div0) begin
              hi    <= rs;
              lo    <= DIV0_LO;
              state <= S_DONE;
            end else begin
              state <= S_NEG_A;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: a bench-side ALU, an arithmetic
// reference model checked every cycle, and directed vectors with literal results.
module tb_alu_muldiv_seq;

  localparam logic [31:0] DIV0_LO   = 32'hFFFFFFFF;
  localparam bit          DIV0_FAST = 1'b1;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done, alu_req;
  logic [31:0] hi, lo, alu_a, alu_b, alu_r;
  logic [3:0]  alu_aluc;

  int checks = 0;
  int errors = 0;

  alu_muldiv_seq #(.DIV0_LO(DIV0_LO), .DIV0_FAST(DIV0_FAST)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_req(alu_req),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r)
  );

  always #5 clk = ~clk;

  // Shared pipeline ALU as seen by the sequencer.
  assign alu_r = (alu_aluc == 4'b0000) ? alu_a + alu_b :
                 (alu_aluc == 4'b0100) ? alu_a - alu_b :
                 (alu_aluc == 4'b0010) ? alu_a ^ alu_b : 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa_l, sb_l, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa_l = longint'(signed'(a));
    sb_l = longint'(signed'(b));
    ua   = {32'h0, a};
    ub   = {32'h0, b};
    case (o)
      2'b00: return 64'(sa_l * sb_l);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'h0) return {a, DIV0_LO};
        q = sa_l / sb_l;
        r = sa_l % sb_l;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, DIV0_LO};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? -x : x;
  endfunction

  // Model: phase 0 idle, 1..36 busy, 37 the done cycle.
  int          ph = 0;
  bit          live = 1'b0;
  logic [1:0]  m_op;
  logic [31:0] m_rs, m_rt;
  logic [31:0] exp_hi, exp_lo, pend_hi, pend_lo;

  always @(posedge clk) begin
    live <= 1'b1;
    if (rst) begin
      ph     <= 0;
      exp_hi <= 32'h0;
      exp_lo <= 32'h0;
    end else if ((ph == 0 || ph == 37) && start) begin
      m_op <= op;
      m_rs <= rs;
      m_rt <= rt;
      if (DIV0_FAST && op[1] && rt == 32'h0) begin
        ph <= 37;
        {exp_hi, exp_lo} <= ref_result(op, rs, rt);
      end else begin
        ph <= 1;
        {pend_hi, pend_lo} <= ref_result(op, rs, rt);
      end
    end else if (ph >= 1 && ph <= 35) begin
      ph <= ph + 1;
    end else if (ph == 36) begin
      ph     <= 37;
      exp_hi <= pend_hi;
      exp_lo <= pend_lo;
    end else if (ph == 37) begin
      ph <= 0;
    end
  end

  // Compare process: status, results and ALU operands every cycle.
  logic [31:0] ma, mb, ea, eb;
  logic [63:0] mprod;
  logic [3:0]  ec;
  bit          ck_ab, exp_busy, sgn, dv;
  always @(negedge clk) begin
    if (live) begin
      exp_busy = (ph >= 1 && ph <= 36);
      check("busy", 64'(busy), 64'(exp_busy));
      check("alu_req", 64'(alu_req), 64'(exp_busy));
      check("done", 64'(done), 64'(ph == 37));
      check("hi", 64'(hi), 64'(exp_hi));
      check("lo", 64'(lo), 64'(exp_lo));

      sgn   = ~m_op[0];
      dv    = m_op[1];
      ma    = mag(m_rs, sgn);
      mb    = mag(m_rt, sgn);
      mprod = {32'h0, ma} * {32'h0, mb};
      ea = 32'h0; eb = 32'h0; ec = 4'b0000; ck_ab = 1'b1;
      if (ph == 1) begin
        eb = m_rs; ec = 4'b0100;
      end else if (ph == 2) begin
        eb = m_rt; ec = 4'b0100;
      end else if (ph == 3) begin
        if (dv) begin ea = {31'h0, ma[31]}; eb = mb; ec = 4'b0100; end
        else    eb = mb[0] ? ma : 32'h0;
      end else if (ph >= 4 && ph <= 34) begin
        ec = dv ? 4'b0100 : 4'b0000; ck_ab = 1'b0;
      end else if (ph == 35) begin
        ec = 4'b0100;
        eb = dv ? ((mb == 0) ? 32'hFFFFFFFF : ma / mb) : mprod[31:0];
      end else if (ph == 36) begin
        if (dv) begin
          ec = 4'b0100; eb = (mb == 0) ? ma : ma % mb;
        end else if (mprod[31:0] == 32'h0) begin
          ec = 4'b0100; eb = mprod[63:32];
        end else begin
          ec = 4'b0010; ea = mprod[63:32]; eb = 32'hFFFFFFFF;
        end
      end
      check("alu_aluc", 64'(alu_aluc), 64'(ec));
      if (ck_ab) begin
        check("alu_a", 64'(alu_a), 64'(ea));
        check("alu_b", 64'(alu_b), 64'(eb));
      end
    end
  end

  // Drives one operation from the current (negedge) time and waits for done.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int elat, input int glitch);
    int lat;
    op = o; rs = a; rt = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 45) begin
      if (lat == glitch) begin
        start = 1'b1; op = 2'b11; rs = 32'h1; rt = 32'h0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(elat));
    check({name, "_hi"}, 64'(hi), 64'(ehi));
    check({name, "_lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs = 32'h0; rt = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_alu_a", 64'(alu_a), 64'(0));
    @(negedge clk);

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 37, 0);
    @(negedge clk);
    check("done_width", 64'(done), 64'(0));
    run_op("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 37, 0);
    run_op("mult_min2", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 37, 0);
    run_op("mult_lz", 2'b00, 32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, 32'h0, 37, 0);
    run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 37, 0);
    run_op("div_7dm2", 2'b10, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 37, 0);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'h2, 32'hE, 37, 0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 37, 0);
    run_op("divu_by0", 2'b11, 32'd100, 32'h0, 32'h64, 32'hFFFFFFFF, 1, 0);
    @(negedge clk);
    check("div0_done_width", 64'(done), 64'(0));

    run_op("ignore_start", 2'b01, 32'h3, 32'h5, 32'h0, 32'hF, 37, 6);
    run_op("b2b", 2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 37, 0);
    @(negedge clk);

    // Abort: reset asserted during cycle k+10 of a multiply.
    op = 2'b01; rs = 32'hFFFFFFFF; rt = 32'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'(0));
    run_op("after_abort", 2'b00, 32'h00012345, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'hFFEDCBB0, 37, 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
